// File: rtl/bmd_axist_ep_pkg.sv
// ---------------------------------------------------------------------------
// bmd_axist_ep_pkg
// Definitions shared by the BMD AXI-ST endpoint PIO request path:
//   - pio_state_e           : PIO request controller FSM states
//   - CPL_SC / CPL_UR       : completion status encodings
//   - RD_LAT_DEFAULT        : default register-file read latency
//   - be_to_byte_count      : first-DW byte enables -> completion byte count
//   - be_to_lower_addr_offset : first-DW byte enables -> byte offset in the DW
// ---------------------------------------------------------------------------
package bmd_axist_ep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_STROBE = 3'd1,
    ST_WR_WAIT   = 3'd2,
    ST_RD_WAIT   = 3'd3,
    ST_CPL       = 3'd4
  } pio_state_e;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  localparam int unsigned RD_LAT_DEFAULT = 2;

  // Bytes spanned from the lowest to the highest enabled byte. An all-zero
  // enable still reports one byte, as a zero-length read does on the link.
  function automatic logic [11:0] be_to_byte_count(input logic [3:0] be);
    logic [11:0] bc;
    casez (be)
      4'b1??1: bc = 12'd4;
      4'b01?1: bc = 12'd3;
      4'b1?10: bc = 12'd3;
      4'b0011: bc = 12'd2;
      4'b0110: bc = 12'd2;
      4'b1100: bc = 12'd2;
      default: bc = 12'd1;  // single enabled byte or no byte enabled
    endcase
    return bc;
  endfunction

  // Index of the lowest enabled byte; 0 when nothing is enabled.
  function automatic logic [1:0] be_to_lower_addr_offset(input logic [3:0] be);
    logic [1:0] off;
    casez (be)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/bmd_axist_ep_cpl_fmt.sv
// ---------------------------------------------------------------------------
// bmd_axist_ep_cpl_fmt
// Combinational completion-descriptor formatter. Works from the registered
// request so its outputs are stable for as long as the request is held.
// Ports:
//   len_one_i     in  1   registered request had length 1 DW
//   addr_i        in  7   registered DW address
//   be_i          in  4   registered first-DW byte enables
//   byte_count_o  out 12  completion byte count
//   lower_addr_o  out 7   completion lower address (byte granularity)
//   status_o      out 3   CPL_SC for a serviceable read, CPL_UR otherwise
// ---------------------------------------------------------------------------
module bmd_axist_ep_cpl_fmt
  import bmd_axist_ep_pkg::*;
(
  input  logic        len_one_i,
  input  logic [6:0]  addr_i,
  input  logic [3:0]  be_i,
  output logic [11:0] byte_count_o,
  output logic [6:0]  lower_addr_o,
  output logic [2:0]  status_o
);

  // Multi-DW reads are unsupported: answer UR with a fixed 4-byte count
  // and a DW-aligned lower address that ignores the byte enables.
  always_comb begin
    byte_count_o = 12'd4;
    lower_addr_o = {addr_i[4:0], 2'b00};
    status_o     = CPL_UR;
    if (len_one_i) begin
      byte_count_o = be_to_byte_count(be_i);
      lower_addr_o = {addr_i[4:0], 2'b00} + {5'b00000, be_to_lower_addr_offset(be_i)};
      status_o     = CPL_SC;
    end else begin
      byte_count_o = 12'd4;
      lower_addr_o = {addr_i[4:0], 2'b00};
      status_o     = CPL_UR;
    end
  end

endmodule

// File: rtl/bmd_axist_ep_pio_req_ctrl.sv
// ---------------------------------------------------------------------------
// bmd_axist_ep_pio_req_ctrl
// PIO request controller: accepts single-DW MRd/MWr requests from the RX
// decoder, drives the register-file access port and returns MRd data to the
// TX engine as a completion descriptor.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_*                      request from RX decoder (valid/ready)
//   addr_o, rd_be_o, rd_data_i register read port (data RD_LAT cycles later)
//   wr_be_o, wr_data_o,
//   wr_en_o, wr_busy_i         register write port with busy handshake
//   cpl_*                      completion descriptor to TX engine (valid/ready)
//   err_drop_o                 one-cycle pulse when a multi-DW write is dropped
// ---------------------------------------------------------------------------
module bmd_axist_ep_pio_req_ctrl
  import bmd_axist_ep_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEFAULT  // 1..16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_wr,
  input  logic [6:0]  req_addr,
  input  logic [9:0]  req_len,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_data,
  input  logic [7:0]  req_tag,
  input  logic [15:0] req_rid,
  input  logic [2:0]  req_tc,
  input  logic [1:0]  req_attr,
  output logic [6:0]  addr_o,
  output logic [3:0]  rd_be_o,
  input  logic [31:0] rd_data_i,
  output logic [7:0]  wr_be_o,
  output logic [31:0] wr_data_o,
  output logic        wr_en_o,
  input  logic        wr_busy_i,
  output logic        cpl_valid,
  input  logic        cpl_ready,
  output logic [31:0] cpl_data,
  output logic [7:0]  cpl_tag,
  output logic [15:0] cpl_rid,
  output logic [2:0]  cpl_tc,
  output logic [1:0]  cpl_attr,
  output logic [2:0]  cpl_status,
  output logic [6:0]  cpl_lower_addr,
  output logic [11:0] cpl_byte_count,
  output logic        err_drop_o
);

  localparam logic [3:0] RD_LAST = 4'(RD_LAT - 32'd1);

  pio_state_e  state_q, state_d;
  logic        ready_q, ready_d;
  logic        len_one_q, len_one_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [3:0]  rd_be_q, rd_be_d;
  logic [7:0]  wr_be_q, wr_be_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  tag_q, tag_d;
  logic [15:0] rid_q, rid_d;
  logic [2:0]  tc_q, tc_d;
  logic [1:0]  attr_q, attr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cpl_data_q, cpl_data_d;
  logic        cpl_valid_q, cpl_valid_d;
  logic        err_drop_q, err_drop_d;

  logic        req_fire_s;
  logic        req_len_one_s;
  logic [11:0] fmt_byte_count_s;
  logic [6:0]  fmt_lower_addr_s;
  logic [2:0]  fmt_status_s;

  // ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign req_fire_s    = req_valid & ready_q;
  assign req_len_one_s = (req_len == 10'd1);

  bmd_axist_ep_cpl_fmt u_cpl_fmt (
    .len_one_i    (len_one_q),
    .addr_i       (addr_q),
    .be_i         (be_q),
    .byte_count_o (fmt_byte_count_s),
    .lower_addr_o (fmt_lower_addr_s),
    .status_o     (fmt_status_s)
  );

  // Next-state, request capture and registered-output computation.
  always_comb begin
    state_d     = state_q;
    len_one_d   = len_one_q;
    addr_d      = addr_q;
    be_d        = be_q;
    rd_be_d     = rd_be_q;
    wr_be_d     = wr_be_q;
    wr_data_d   = wr_data_q;
    tag_d       = tag_q;
    rid_d       = rid_q;
    tc_d        = tc_q;
    attr_d      = attr_q;
    cnt_d       = cnt_q;
    cpl_data_d  = cpl_data_q;
    err_drop_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_fire_s) begin
          len_one_d = req_len_one_s;
          addr_d    = req_addr;
          be_d      = req_be;
          rd_be_d   = req_is_wr ? 4'b0000 : req_be;
          wr_be_d   = req_is_wr ? {4'b0000, req_be} : 8'h00;
          wr_data_d = req_is_wr ? req_data : 32'h0000_0000;
          tag_d     = req_tag;
          rid_d     = req_rid;
          tc_d      = req_tc;
          attr_d    = req_attr;
          cnt_d     = 4'd0;
          cpl_data_d = 32'h0000_0000;
          if (req_is_wr) begin
            if (req_len_one_s) begin
              state_d = ST_WR_STROBE;
            end else begin
              // Multi-DW writes are not supported: drop with a flag only.
              err_drop_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end else begin
            if (req_len_one_s) begin
              state_d = ST_RD_WAIT;
            end else begin
              state_d = ST_CPL;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_STROBE: begin
        // Busy may already be asserted here; it is only honoured in WR_WAIT.
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (wr_busy_i) begin
          state_d = ST_WR_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        // Address has been stable since acceptance; data is valid on the
        // RD_LAT-th edge after it.
        if (cnt_q == RD_LAST) begin
          cpl_data_d = rd_data_i;
          state_d    = ST_CPL;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ST_RD_WAIT;
        end
      end
      ST_CPL: begin
        if (cpl_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CPL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d     = (state_d == ST_IDLE);
    wr_en_d     = (state_d == ST_WR_STROBE);
    cpl_valid_d = (state_d == ST_CPL);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      len_one_q   <= 1'b0;
      addr_q      <= 7'd0;
      be_q        <= 4'd0;
      rd_be_q     <= 4'd0;
      wr_be_q     <= 8'd0;
      wr_data_q   <= 32'd0;
      wr_en_q     <= 1'b0;
      tag_q       <= 8'd0;
      rid_q       <= 16'd0;
      tc_q        <= 3'd0;
      attr_q      <= 2'd0;
      cnt_q       <= 4'd0;
      cpl_data_q  <= 32'd0;
      cpl_valid_q <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      len_one_q   <= len_one_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      rd_be_q     <= rd_be_d;
      wr_be_q     <= wr_be_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      tag_q       <= tag_d;
      rid_q       <= rid_d;
      tc_q        <= tc_d;
      attr_q      <= attr_d;
      cnt_q       <= cnt_d;
      cpl_data_q  <= cpl_data_d;
      cpl_valid_q <= cpl_valid_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign req_ready  = ready_q;
  assign addr_o     = addr_q;
  assign rd_be_o    = rd_be_q;
  assign wr_be_o    = wr_be_q;
  assign wr_data_o  = wr_data_q;
  assign wr_en_o    = wr_en_q;
  assign err_drop_o = err_drop_q;

  assign cpl_valid  = cpl_valid_q;
  assign cpl_data   = cpl_data_q;
  assign cpl_tag    = tag_q;
  assign cpl_rid    = rid_q;
  assign cpl_tc     = tc_q;
  assign cpl_attr   = attr_q;
  // Formatter outputs are forced to zero outside CPL so that the idle
  // register state (length 0) does not show up as a UR descriptor.
  assign cpl_status     = cpl_valid_q ? fmt_status_s     : 3'b000;
  assign cpl_lower_addr = cpl_valid_q ? fmt_lower_addr_s : 7'd0;
  assign cpl_byte_count = cpl_valid_q ? fmt_byte_count_s : 12'd0;

endmodule
